unified_mem_arbiter: RTL and testbench

- Shares one single-port, variable-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store from the EX/MEM pipeline register outputs).
- Serves one transaction at a time, with MEM-stage priority over IF.
- Generates a global pipeline stall until every pending requester has been served.
- Includes a watchdog that aborts hung memory transactions.

---
 rtl/cpu_mem_pkg.sv | 12 +
 rtl/mem_wait_watchdog.sv | 23 ++
 rtl/unified_mem_arbiter.sv | 111 +++++++++++
 tb/tb_unified_mem_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package cpu_mem_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int unsigned ABORT_DATA = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_wait_watchdog.sv
// Wait-cycle counter for one memory transaction; flags expiry on the last
// allowed waiting cycle so the owner can abort at that edge.
module mem_wait_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cnt <= '0;
    else if (clr)            cnt <= '0;
    else if (en && !expired) cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory shared by fetch and load/store; MEM stage wins, one
// transaction at a time, pipeline stalled until every pending requester is served.
module unified_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_served,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_served,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              bus_err
);
  arb_state_t state;
  logic dm_pend, if_pend, expired;

  assign dm_pend = (dm_read | dm_write) & ~dm_served;
  assign if_pend = if_req & ~if_served;
  assign stall   = dm_pend | if_pend;

  mem_wait_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_served <= 1'b0;
      dm_served <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      // Pipeline advanced: served flags retire. A completion below overrides.
      if (!stall) begin
        if_served <= 1'b0;
        dm_served <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (dm_pend) begin
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_we    <= dm_write;
            mem_req   <= 1'b1;
            state     <= DATA;
          end else if (if_pend) begin
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            state    <= INST;
          end
        end
        DATA: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            dm_served <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
            state     <= IDLE;
          end else if (expired) begin
            mem_req   <= 1'b0;
            dm_served <= 1'b1;
            dm_rdata  <= DATA_W'(ABORT_DATA);
            bus_err   <= 1'b1;
            state     <= IDLE;
          end
        end
        INST: begin
          if (mem_ready) begin
            mem_req   <= 1'b0;
            if_served <= 1'b1;
            if_rdata  <= mem_rdata;
            state     <= IDLE;
          end else if (expired) begin
            mem_req   <= 1'b0;
            if_served <= 1'b1;
            if_rdata  <= DATA_W'(ABORT_DATA);
            bus_err   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for the unified memory arbiter: fetch, load+fetch, store,
// timeout abort, async reset mid-transaction and stall release.
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_served;
  logic        dm_read, dm_write;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_served;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall, bus_err;

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_served(if_served),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_served(dm_served),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; if_req = 0; if_addr = 0; dm_read = 0; dm_write = 0;
    dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rdata = 0;
    cyc(); cyc();
    total++; if ({mem_req, mem_we, if_served, dm_served, bus_err, stall} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {mem_req, mem_we, if_served, dm_served, bus_err, stall}); end
    total++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, if_rdata, dm_rdata}); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_fetch();
    int n = 0;
    if_req = 1; if_addr = 32'h40; #1;
    total++; if (stall !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL fetch_t0 stall=%b mem_req=%b exp stall=1 mem_req=0", stall, mem_req); end
    cyc(); n += int'(mem_req);
    total++; if (mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      bad++; $display("FAIL fetch_addr got=%h we=%b exp=40 we=0", mem_addr, mem_we); end
    cyc(); n += int'(mem_req);
    cyc(); n += int'(mem_req); mem_ready = 1; mem_rdata = 32'h8C220004;
    cyc(); n += int'(mem_req); mem_ready = 0; #1;
    total++; if (n !== 3) begin bad++; $display("FAIL fetch_req_cycles got=%0d exp=3", n); end
    total++; if (if_served !== 1'b1 || stall !== 1'b0 || if_rdata !== 32'h8C220004) begin
      bad++; $display("FAIL fetch_done served=%b stall=%b rdata=%h exp 1 0 8c220004", if_served, stall, if_rdata); end
    if_req = 0;
    cyc();
    total++; if (if_served !== 1'b0) begin bad++; $display("FAIL fetch_clear got=%b exp=0", if_served); end
  endtask

  task automatic test_load_fetch();
    dm_read = 1; dm_addr = 32'h100; if_req = 1; if_addr = 32'h44;
    cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      bad++; $display("FAIL lf_first req=%b addr=%h we=%b exp 1 100 0", mem_req, mem_addr, mem_we); end
    mem_ready = 1; mem_rdata = 32'h11223344;
    cyc(); mem_ready = 0; #1;
    total++; if (dm_served !== 1'b1 || dm_rdata !== 32'h11223344 || stall !== 1'b1 || mem_req !== 1'b0) begin
      bad++; $display("FAIL lf_load served=%b rdata=%h stall=%b req=%b exp 1 11223344 1 0", dm_served, dm_rdata, stall, mem_req); end
    cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || stall !== 1'b1) begin
      bad++; $display("FAIL lf_second req=%b addr=%h stall=%b exp 1 44 1", mem_req, mem_addr, stall); end
    mem_ready = 1; mem_rdata = 32'h22222222;
    cyc(); mem_ready = 0; #1;
    total++; if (if_served !== 1'b1 || dm_served !== 1'b1 || stall !== 1'b0 || if_rdata !== 32'h22222222) begin
      bad++; $display("FAIL lf_both if_s=%b dm_s=%b stall=%b rdata=%h exp 1 1 0 22222222", if_served, dm_served, stall, if_rdata); end
    dm_read = 0; if_req = 0;
    cyc();
    total++; if (if_served !== 1'b0 || dm_served !== 1'b0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL release_clear if_s=%b dm_s=%b req=%b exp 0 0 0", if_served, dm_served, mem_req); end
    if_req = 1; if_addr = 32'h48;
    cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h48) begin
      bad++; $display("FAIL release_restart req=%b addr=%h exp 1 48", mem_req, mem_addr); end
    mem_ready = 1; mem_rdata = 32'h33333333;
    cyc(); mem_ready = 0; if_req = 0;
    cyc();
  endtask

  task automatic test_store();
    int held = 1;
    dm_write = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 1) dm_wdata = 32'h0;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h200) held = 0;
    end
    total++; if (held !== 1) begin
      bad++; $display("FAIL store_hold req=%b we=%b wdata=%h addr=%h exp 1 1 deadbeef 200", mem_req, mem_we, mem_wdata, mem_addr); end
    cyc(); mem_ready = 1; mem_rdata = 32'hBAD0BAD0;
    cyc(); mem_ready = 0; #1;
    total++; if (dm_served !== 1'b1 || dm_rdata !== 32'h11223344 || stall !== 1'b0) begin
      bad++; $display("FAIL store_done served=%b rdata=%h stall=%b exp 1 11223344 0", dm_served, dm_rdata, stall); end
    dm_write = 0;
    cyc();
  endtask

  task automatic test_timeout();
    int n = 0;
    dm_read = 1; dm_addr = 32'h300;
    cyc();
    while (mem_req === 1'b1 && n < 40) begin n++; cyc(); end
    total++; if (n !== 15) begin bad++; $display("FAIL timeout_cycles got=%0d exp=15", n); end
    total++; if (dm_served !== 1'b1 || dm_rdata !== 32'h0 || bus_err !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL timeout_abort served=%b rdata=%h err=%b stall=%b exp 1 0 1 0", dm_served, dm_rdata, bus_err, stall); end
    dm_read = 0;
    cyc();
    if_req = 1; if_addr = 32'h50;
    cyc(); mem_ready = 1; mem_rdata = 32'h44444444;
    cyc(); mem_ready = 0; #1;
    total++; if (bus_err !== 1'b1 || if_rdata !== 32'h44444444 || if_served !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky err=%b rdata=%h served=%b exp 1 44444444 1", bus_err, if_rdata, if_served); end
    if_req = 0;
    cyc();
  endtask

  task automatic test_async_reset();
    dm_read = 1; dm_addr = 32'h400;
    cyc();
    cyc();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ar_pre req=%b exp 1", mem_req); end
    reset = 1; dm_read = 0; #1;
    total++; if ({mem_req, stall, if_served, dm_served, bus_err} !== 5'b0 || dm_rdata !== 32'h0) begin
      bad++; $display("FAIL ar_immediate flags=%b dm_rdata=%h exp 00000 0", {mem_req, stall, if_served, dm_served, bus_err}, dm_rdata); end
    cyc();
    reset = 0;
    cyc();
    if_req = 1; if_addr = 32'h60;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b1) begin
      bad++; $display("FAIL ar_fresh_t0 req=%b stall=%b exp 0 1", mem_req, stall); end
    cyc();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h60 || mem_we !== 1'b0) begin
      bad++; $display("FAIL ar_fresh req=%b addr=%h we=%b exp 1 60 0", mem_req, mem_addr, mem_we); end
    mem_ready = 1; mem_rdata = 32'h55555555;
    cyc(); mem_ready = 0; #1;
    total++; if (if_served !== 1'b1 || if_rdata !== 32'h55555555 || bus_err !== 1'b0) begin
      bad++; $display("FAIL ar_done served=%b rdata=%h err=%b exp 1 55555555 0", if_served, if_rdata, bus_err); end
    if_req = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load_fetch();
    test_store();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
